// File: rtl/nw_pkg.sv
// nw_pkg: symbol codes, ASCII constants and loader FSM states shared by the sequence loader.
package nw_pkg;
  localparam logic [2:0] SYM_GAP = 3'd0, SYM_A = 3'd1, SYM_C = 3'd2, SYM_G = 3'd3, SYM_T = 3'd4;
  localparam logic [7:0] ASC_LF = 8'h0A, ASC_SEMI = 8'h3B, ASC_CR = 8'h0D, ASC_SP = 8'h20;
  localparam logic [7:0] ASC_A = 8'h41, ASC_C = 8'h43, ASC_G = 8'h47, ASC_T = 8'h54;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, DONE, PAD_A, PAD_B} state_t;
endpackage

// File: rtl/nw_ascii_enc.sv
// nw_ascii_enc: classifies an ASCII byte as base, terminator or skip and encodes bases to 3-bit symbols.
module nw_ascii_enc
  import nw_pkg::*;
(
  input  logic [7:0] in_data,
  output logic       is_base,
  output logic       is_term,
  output logic       is_skip,
  output logic [2:0] code
);
  logic [7:0] up;
  // Clearing bit 5 folds lowercase letters onto uppercase; only 'a'/'A' etc. collide.
  assign up = in_data & 8'hDF;
  always_comb begin
    code = up == ASC_A ? SYM_A : up == ASC_C ? SYM_C : up == ASC_G ? SYM_G : up == ASC_T ? SYM_T : SYM_GAP;
  end
  assign is_base = code != SYM_GAP;
  assign is_term = in_data == ASC_LF || in_data == ASC_SEMI;
  assign is_skip = in_data == ASC_CR || in_data == ASC_SP;
endmodule

// File: rtl/nw_seq_loader.sv
// nw_seq_loader: streams ASCII nucleotides into the A then B sequence RAMs at addresses 1..len.
// Define NW_SEQ_LOADER_PAD_EN to gap-fill addresses len+1..N after each terminator.
module nw_seq_loader
  import nw_pkg::*;
#(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             we_a,
  output logic             we_b,
  output logic [BitAddr:0] addr,
  output logic [2:0]       din,
  output logic [BitAddr:0] len_a,
  output logic [BitAddr:0] len_b,
  output logic             load_done,
  output logic             err_bad_char,
  output logic             err_overflow
);
  localparam int W = BitAddr + 1;
  localparam logic [BitAddr:0] NMAX = W'(N);
  state_t state, state_n;
  logic is_base, is_term, is_skip, acc, in_a;
  logic [2:0] code;
  logic [BitAddr:0] len_x;
`ifdef NW_SEQ_LOADER_PAD_EN
  logic [BitAddr:0] pad_ptr;
`endif
  nw_ascii_enc u_enc (
    .in_data (in_data),
    .is_base (is_base),
    .is_term (is_term),
    .is_skip (is_skip),
    .code    (code)
  );
  assign in_ready  = state == LOAD_A || state == LOAD_B;
  assign load_done = state == DONE;
  assign acc       = in_valid && in_ready;
  assign in_a      = state == LOAD_A;
  assign len_x     = in_a ? len_a : len_b;
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE:     state_n = start ? LOAD_A : state;
      LOAD_A, LOAD_B: if (acc && is_term && len_x != '0)
`ifdef NW_SEQ_LOADER_PAD_EN
        state_n = len_x == NMAX ? (in_a ? LOAD_B : DONE) : (in_a ? PAD_A : PAD_B);
      PAD_A:          state_n = pad_ptr > NMAX ? LOAD_B : state;
      PAD_B:          state_n = pad_ptr > NMAX ? DONE : state;
`else
        state_n = in_a ? LOAD_B : DONE;
`endif
      default:        state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      we_a         <= 1'b0;
      we_b         <= 1'b0;
      addr         <= '0;
      din          <= SYM_GAP;
      len_a        <= '0;
      len_b        <= '0;
      err_bad_char <= 1'b0;
      err_overflow <= 1'b0;
`ifdef NW_SEQ_LOADER_PAD_EN
      pad_ptr      <= '0;
`endif
    end else begin
      state <= state_n;
      we_a  <= 1'b0;
      we_b  <= 1'b0;
      if ((state == IDLE || state == DONE) && start) begin
        len_a        <= '0;
        len_b        <= '0;
        err_bad_char <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (acc && is_base) begin
        if (len_x == NMAX) err_overflow <= 1'b1;
        else begin
          we_a <= in_a;
          we_b <= !in_a;
          addr <= len_x + 1'b1;
          din  <= code;
          if (in_a) len_a <= len_a + 1'b1;
          else len_b <= len_b + 1'b1;
        end
      end
      if (acc && !is_base && !is_term && !is_skip) err_bad_char <= 1'b1;
`ifdef NW_SEQ_LOADER_PAD_EN
      if (acc && is_term) pad_ptr <= len_x + 1'b1;
      if ((state == PAD_A || state == PAD_B) && pad_ptr <= NMAX) begin
        we_a    <= state == PAD_A;
        we_b    <= state == PAD_B;
        addr    <= pad_ptr;
        din     <= SYM_GAP;
        pad_ptr <= pad_ptr + 1'b1;
      end
`endif
    end
  end
endmodule

// File: tb/tb_nw_seq_loader.sv
// tb_nw_seq_loader: directed checks of nw_seq_loader at N=128 (dut0) and N=4 (dut1).
module tb_nw_seq_loader;
  logic clk = 1'b0, rst = 1'b1, clr = 1'b0;
  logic s0 = 1'b0, v0 = 1'b0, s1 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic r0, wa0, wb0, ld0, eb0, eo0, r1, wa1, wb1, ld1, eb1, eo1;
  logic [8:0] ad0, la0, lb0;
  logic [3:0] ad1, la1, lb1;
  logic [2:0] dn0, dn1;
  logic [2:0] ma0 [0:511], mb0 [0:511], ma1 [0:15], mb1 [0:15];
  logic bad0, bad1;
  int wca1;
  int n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  nw_seq_loader dut0 (
    .clk(clk), .rst(rst), .start(s0), .in_valid(v0), .in_data(d0), .in_ready(r0),
    .we_a(wa0), .we_b(wb0), .addr(ad0), .din(dn0), .len_a(la0), .len_b(lb0),
    .load_done(ld0), .err_bad_char(eb0), .err_overflow(eo0)
  );
  nw_seq_loader #(.N(4)) dut1 (
    .clk(clk), .rst(rst), .start(s1), .in_valid(v1), .in_data(d1), .in_ready(r1),
    .we_a(wa1), .we_b(wb1), .addr(ad1), .din(dn1), .len_a(la1), .len_b(lb1),
    .load_done(ld1), .err_bad_char(eb1), .err_overflow(eo1)
  );

  // RAM models: capture writes; flag double strobes, address-0 writes and writes while done
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 512; i++) begin ma0[i] = 3'd7; mb0[i] = 3'd7; end
      for (int i = 0; i < 16; i++) begin ma1[i] = 3'd7; mb1[i] = 3'd7; end
      wca1 = 0; bad0 = 1'b0; bad1 = 1'b0;
    end else if (!rst) begin
      if (wa0) ma0[ad0] = dn0;
      if (wb0) mb0[ad0] = dn0;
      if (wa1) begin ma1[ad1] = dn1; wca1++; end
      if (wb1) mb1[ad1] = dn1;
      if ((wa0 && wb0) || ((wa0 || wb0) && (ad0 == 9'd0 || ld0))) bad0 = 1'b1;
      if ((wa1 && wb1) || ((wa1 || wb1) && (ad1 == 4'd0 || ld1))) bad1 = 1'b1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    if (sel == 0) s0 = 1'b1; else s1 = 1'b1;
    @(negedge clk);
    s0 = 1'b0; s1 = 1'b0;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input bit rnd);
    int t = 0;
    @(negedge clk);
    while (rnd && $urandom_range(1, 0) == 0) begin
      if (sel == 0) v0 = 1'b0; else v1 = 1'b0;
      @(negedge clk);
    end
    if (sel == 0) begin v0 = 1'b1; d0 = b; end else begin v1 = 1'b1; d1 = b; end
    while (((sel == 0) ? r0 : r1) !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic send_str(input int sel, input string s, input bit rnd);
    for (int i = 0; i < s.len(); i++) send_byte(sel, s[i], rnd);
    #1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int t = 0;
    while (((sel == 0) ? ld0 : ld1) !== 1'b1 && t < 600) begin @(negedge clk); t++; end
    chk("load_done", 32'((sel == 0) ? ld0 : ld1), 1);
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_ready", 32'(r0), 0);
    chk("rst_we", 32'({wa0, wb0}), 0);
    chk("rst_addr_din", 32'({ad0, dn0}), 0);
    chk("rst_len", 32'({la0, lb0}), 0);
    chk("rst_flags", 32'({ld0, eb0, eo0}), 0);
    @(negedge clk); rst = 1'b0;
    chk("idle_ready", 32'(r0), 0);
    clear_mon();

    // "ACGT\nga;" with latency check on the first base
    pulse_start(0);
    chk("ready_load_a", 32'(r0), 1);
    v0 = 1'b1; d0 = "A";
    @(posedge clk); #1;
    chk("lat_we_a", 32'({wa0, wb0}), 2);
    chk("lat_addr", 32'(ad0), 1);
    chk("lat_din", 32'(dn0), 1);
    chk("lat_len_a", 32'(la0), 1);
    send_str(0, "CGT\nga;", 1'b0);
    wait_done(0);
    for (int i = 1; i <= 4; i++) chk("t1_mem_a", 32'(ma0[i]), i);
    chk("t1_mem_b1", 32'(mb0[1]), 3);
    chk("t1_mem_b2", 32'(mb0[2]), 1);
    chk("t1_mem_a0", 32'(ma0[0]), 7);
    chk("t1_len", 32'({la0, lb0}), (4 << 9) | 2);
    chk("t1_err", 32'({eb0, eo0}), 0);
    chk("t1_ready_done", 32'(r0), 0);
    @(negedge clk);
    chk("t1_no_write_done", 32'({wa0, wb0}), 0);
    chk("t1_strobes", 32'(bad0), 0);

    // "AXC\nT\n" with an ignored start mid-load
    clear_mon();
    pulse_start(0);
    chk("t2_len_cleared", 32'({la0, lb0}), 0);
    chk("t2_done_cleared", 32'(ld0), 0);
    send_str(0, "AX", 1'b0);
    chk("t2_bad_char", 32'(eb0), 1);
    pulse_start(0);
    send_str(0, "C\nT\n", 1'b0);
    wait_done(0);
    chk("t2_mem_a1", 32'(ma0[1]), 1);
    chk("t2_mem_a2", 32'(ma0[2]), 2);
    chk("t2_mem_b1", 32'(mb0[1]), 4);
    chk("t2_len", 32'({la0, lb0}), (2 << 9) | 1);
    chk("t2_err", 32'({eb0, eo0}), 2);
    chk("t2_strobes", 32'(bad0), 0);

    // N=4 overflow: "ACGTA\nC\n"
    clear_mon();
    pulse_start(1);
    send_str(1, "ACGTA\nC\n", 1'b0);
    wait_done(1);
    chk("t3_overflow", 32'(eo1), 1);
    chk("t3_bad_char", 32'(eb1), 0);
    chk("t3_len", 32'({la1, lb1}), (4 << 4) | 1);
    chk("t3_a_writes", wca1, 4);
    for (int i = 1; i <= 4; i++) chk("t3_mem_a", 32'(ma1[i]), i);
    chk("t3_mem_b1", 32'(mb1[1]), 2);
    chk("t3_strobes", 32'(bad1), 0);
    chk("t2_errs_cleared", 32'({eb0, eo0}), 2);

    // "\nAC\n;G;" held, then with random valid gaps
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      pulse_start(0);
      chk("t4_err_cleared", 32'({eb0, eo0}), 0);
      send_str(0, "\nAC\n;G;", k == 1);
      wait_done(0);
      chk("t4_len", 32'({la0, lb0}), (2 << 9) | 1);
      chk("t4_mem_a1", 32'(ma0[1]), 1);
      chk("t4_mem_a2", 32'(ma0[2]), 2);
      chk("t4_mem_b1", 32'(mb0[1]), 3);
      chk("t4_mem_a0", 32'(ma0[0]), 7);
      chk("t4_strobes", 32'(bad0), 0);
    end

    // async reset after two bases of A, then a fresh load
    clear_mon();
    pulse_start(0);
    send_str(0, "AC", 1'b0);
    chk("t5_pending_we", 32'(wa0), 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_we", 32'({wa0, wb0}), 0);
    chk("t5_rst_len", 32'({la0, lb0}), 0);
    chk("t5_rst_addr", 32'(ad0), 0);
    chk("t5_rst_ready", 32'(r0), 0);
    @(negedge clk); rst = 1'b0;
    clear_mon();
    pulse_start(0);
    send_str(0, "T\nG\n", 1'b0);
    wait_done(0);
    chk("t5_mem_a1", 32'(ma0[1]), 4);
    chk("t5_mem_b1", 32'(mb0[1]), 3);
    chk("t5_mem_a2", 32'(ma0[2]), 7);
    chk("t5_len", 32'({la0, lb0}), (1 << 9) | 1);

`ifdef NW_SEQ_LOADER_PAD_EN
    // padding at N=4: "AC\nG\n"
    clear_mon();
    pulse_start(1);
    send_str(1, "AC\n", 1'b0);
    @(negedge clk);
    chk("t6_ready_pad", 32'(r1), 0);
    send_str(1, "G\n", 1'b0);
    wait_done(1);
    chk("t6_mem_a1", 32'(ma1[1]), 1);
    chk("t6_mem_a2", 32'(ma1[2]), 2);
    chk("t6_mem_a3", 32'(ma1[3]), 0);
    chk("t6_mem_a4", 32'(ma1[4]), 0);
    chk("t6_mem_b1", 32'(mb1[1]), 3);
    for (int i = 2; i <= 4; i++) chk("t6_mem_b_pad", 32'(mb1[i]), 0);
    chk("t6_len", 32'({la1, lb1}), (2 << 4) | 1);
    chk("t6_strobes", 32'(bad1), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/nw_seq_loader.md
Name: nw_seq_loader

Overview:
Writer side of the sequence memories that the alignment datapath reads by index during fill and traceback. It accepts a byte stream of ASCII nucleotides over a valid/ready handshake and encodes each one to the 3-bit symbol code. It writes sequence A, then sequence B, into their RAMs at addresses 1..len, reports both lengths, and raises load_done. The controller then starts init/fill.

Parameters:
N, 128, maximum length of each sequence
BitAddr, $clog2(N+1), index width minus one; indices and lengths are BitAddr+1 bits, matching i/j

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load, accepted only in IDLE or DONE
in_valid  in  1  in_data valid
in_data  in  8  ASCII character
in_ready  out  1  loader can accept in_data this cycle
we_a  out  1  write strobe, sequence A RAM
we_b  out  1  write strobe, sequence B RAM
addr  out  BitAddr+1  write address, shared by both RAMs
din  out  3  encoded symbol to write
len_a  out  BitAddr+1  symbols stored for A
len_b  out  BitAddr+1  symbols stored for B
load_done  out  1  level; both sequences loaded
err_bad_char  out  1  sticky; an illegal character was dropped
err_overflow  out  1  sticky; a symbol beyond N was dropped

Behaviour:
- Reset values: all outputs 0; state IDLE. RAM contents are not touched.
- Encoding (case-insensitive): A=3'd1, C=3'd2, G=3'd3, T=3'd4. 3'd0 is the gap/empty code and is never produced from input.
- Terminators: LF (0x0A) or ';' (0x3B). Ignored silently: CR (0x0D), space (0x20). Any other byte is dropped and sets err_bad_char.
- FSM states: IDLE, LOAD_A, LOAD_B, DONE, plus PAD_A and PAD_B (optional feature only).
- IDLE/DONE + start: clear len_a, len_b, both error flags and load_done; go to LOAD_A.
- start in any other state: ignored.
- in_ready = 1 only in LOAD_A and LOAD_B.
- A byte is accepted when in_valid && in_ready.
- LOAD_x accepting a base with len_x < N:
  - next cycle: we_x=1, addr=len_x+1, din=code; len_x increments in the same cycle.
  - write latency is exactly 1 cycle; strobes last one cycle; back-to-back accepts give back-to-back writes.
- LOAD_x accepting a base with len_x == N: no write, err_overflow set, stay in LOAD_x.
- LOAD_x accepting a terminator:
  - LOAD_A -> LOAD_B.
  - LOAD_B -> DONE; load_done=1 from the following cycle.
  - With the optional feature, the next state is PAD_x instead.
- Terminator with len_x == 0: accepted, no state change. Empty sequences are not allowed.
- Address 0 is never written; row/column 0 is owned by init.
- Only one of we_a/we_b can be high in any cycle.
- No write strobe is issued in IDLE or DONE.
- Async rst mid-load: immediate return to IDLE, outputs cleared, any pending write cancelled. Partial RAM contents are stale and must not be used.

Optional Feature:
Macro NW_SEQ_LOADER_PAD_EN.
- Defined: after the terminator of sequence x, state PAD_x writes din=0 to addresses len_x+1..N, one per cycle, with in_ready=0.
  - PAD_A then goes to LOAD_B.
  - PAD_B then goes to DONE.
  - If len_x == N, padding takes 0 cycles.
- Undefined: no PAD states; addresses above len_x keep old contents.

Decomposition:
- Shared package nw_pkg holds:
  - symbol codes SYM_GAP/SYM_A/SYM_C/SYM_G/SYM_T
  - ASCII constants for LF, ';', CR, space
  - FSM state encoding
- One combinational sub-module, nw_ascii_enc: in_data -> {is_base, is_term, is_skip, code[2:0]}.

Test Plan:
- Stream "ACGT\nga;" with in_valid held high:
  - writes A addr1..4 = 1,2,3,4; B addr1..2 = 3,1
  - len_a=4, len_b=2; load_done=1; no errors.
- Stream "AXC\nT\n": X dropped, err_bad_char=1; A addr1=1, addr2=2; len_a=2; load finishes normally.
- N=4, stream "ACGTA\nC\n": fifth base dropped, err_overflow=1, len_a=4; B loads len_b=1.
- Stream "\nAC\n;G;": leading LF ignored; len_a=2, len_b=1; in_valid toggled randomly gives the same writes.
- rst asserted after 2 bases of A: outputs 0 and IDLE immediately; start again loads correctly from addr 1.
- With NW_SEQ_LOADER_PAD_EN, N=4, "AC\nG\n": A addr3,4=0 and B addr2..4=0 written; in_ready low during padding; load_done after the last pad write.
